uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that pairs with the existing UART transmitter (`main`).
- Deserializes an 8N1 frame (LSB first, idle-high line) from `serial_in_i` into a byte, using a mid-bit sampling baud counter.
- Holds the byte in an output register with a valid/read handshake and reports framing and overrun errors.
- Sits at the serial pin on the receive side; the host logic consumes bytes.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per bit period; must be even and >= 4.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- serial_in_i  input  1  asynchronous serial line; idles at 1.
- read_i  input  1  host pulse that consumes the held byte.
- data_o  output  8  last received byte.
- data_valid_o  output  1  `data_o` holds an unread byte.
- frame_err_o  output  1  stop bit of the byte in `data_o` was 0.
- overrun_o  output  1  sticky; a frame was dropped because `data_valid_o` was still set.
- busy_o  output  1  receiver is inside a frame (state != IDLE).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; baud counter and bit index = 0.
  - Synchronizer flops = 1.
  - Shift register = 0.
  - `data_o` = 0; `data_valid_o`, `frame_err_o`, `overrun_o`, `busy_o` = 0.
  - Reset mid-frame abandons the frame with no output update.
- Synchronizer: 2-flop synchronizer on `serial_in_i`; `rx_s` is its output. All decisions use `rx_s` only.
- Baud counter `cnt` counts 0..CLKS_PER_BIT-1 and is cleared on every state change. Let H = CLKS_PER_BIT/2.
- States:
  - IDLE: if `rx_s` = 0, go to START.
  - START: when `cnt` = H-1, sample `rx_s`. If 0, go to DATA with bit index = 0. If 1, the start was a glitch: go to IDLE, no flags.
  - DATA: when `cnt` = CLKS_PER_BIT-1, shift `rx_s` into the MSB and shift right (LSB-first assembly). After bit index 7, go to STOP (or PARITY when the optional feature is compiled in).
  - STOP: when `cnt` = CLKS_PER_BIT-1, complete the frame. If `rx_s` = 1, go to IDLE. If `rx_s` = 0, go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. No new start detection occurs while in BREAK.
- Frame completion, on the STOP sampling edge:
  - If `data_valid_o` = 0, or `read_i` = 1 on the same edge: load `data_o` from the shift register, set `frame_err_o` = !`rx_s`, set `data_valid_o` = 1.
  - Otherwise: drop the frame. `data_o` and `frame_err_o` are unchanged and `overrun_o` is set.
- Read handshake:
  - `read_i` with `data_valid_o` = 1 clears `data_valid_o` and `overrun_o` on the next edge, unless a frame completes on that same edge. In that case `data_valid_o` stays 1 and the new byte is loaded.
  - `read_i` with `data_valid_o` = 0 is ignored.
- Latency: let E0 be the first edge that samples `serial_in_i` = 0. `data_valid_o` is high after edge E0 + 2 + H + 9*CLKS_PER_BIT. With CLKS_PER_BIT = 4 this is E0+40.
- `busy_o` is a registered decode of state != IDLE.
- Back-to-back frames: a start bit immediately following a valid stop bit is detected. IDLE needs only one cycle with `rx_s` = 0.

Optional Feature:
Macro: UART_RX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at `cnt` = CLKS_PER_BIT-1.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - Adds an output port `parity_err_o` (1 bit). It is loaded alongside `frame_err_o` and is 0 on reset.
  - Latency grows by CLKS_PER_BIT.
- Not defined: 8N1 only; no PARITY state and no `parity_err_o` port.

Test Plan:
- Reset, then drive frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1), each bit 4 clocks wide -> `data_o` = 0x55, `data_valid_o` rises at E0+40, `frame_err_o` = 0, `busy_o` falls the same cycle.
- Drive a 2-clock low glitch on an idle line -> state returns to IDLE, `data_valid_o` stays 0, no error flags.
- Frame 0xA3 with stop bit forced 0, line held low 12 clocks then high -> `data_o` = 0xA3, `frame_err_o` = 1; no spurious frame until the line returns high; next frame 0x0F is received correctly.
- Frames 0x11 then 0x22 back-to-back with no `read_i` -> `data_o` = 0x11, `overrun_o` = 1. A `read_i` pulse then clears both `data_valid_o` and `overrun_o`.
- Assert `read_i` on the exact edge the second frame (0x22) completes -> `data_valid_o` stays 1, `data_o` = 0x22, `overrun_o` = 0.
- Assert `reset_i` for one cycle in the middle of DATA of frame 0xFF -> all outputs 0 and `busy_o` = 0 next cycle; a following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (LSB first, idle-high line).
//
// The serial line goes through a two-flop synchronizer. A baud counter then
// samples each bit in the middle of its period. The finished byte is held in an
// output register with a valid/read handshake. The receiver reports a framing
// error (stop bit low) and a sticky overrun flag (a frame was dropped because
// the held byte had not been read).
//
// Optional feature, selected by the macro UART_RX_PARITY_EN:
//   When defined, an even-parity bit follows the data bits. The result of the
//   parity check is reported on parity_err_o.
//   When undefined, the receiver is 8N1 only and parity_err_o does not exist.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (even, >= 4)
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       synchronous active-high reset
//   serial_in_i   asynchronous serial line, idles high
//   read_i        host pulse that consumes the held byte
//   data_o        last received byte
//   data_valid_o  data_o holds an unread byte
//   frame_err_o   stop bit of the byte in data_o was 0
//   parity_err_o  (UART_RX_PARITY_EN only) parity of the byte in data_o was bad
//   overrun_o     sticky: a frame was dropped while data_valid_o was set
//   busy_o        receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       serial_in_i,
    input  logic       read_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    // Synchronizer: bit 0 is the first stage and bit 1 is the output.
    logic [1:0]       sync_reg;
    logic             rx_s;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg, overrun_next;
    logic             busy_reg, busy_next;
    logic             complete;
    logic             load;
    logic             drop;
    logic             take;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_reg, parity_bad_next;
    logic             parity_err_reg, parity_err_next;
`endif

    assign rx_s = sync_reg[1];

    // ------------------------------------------------------------------
    // Frame FSM and baud counter
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = parity_bad_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // Check the start bit again at mid-bit. A line that is
                // already high again was only a glitch.
                if (cnt_reg == CNT_HALF) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                    bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                // The counter was realigned at mid start bit, so CNT_LAST
                // falls in the middle of each data bit.
                if (cnt_reg == CNT_LAST) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == CNT_LAST) begin
                    // Even parity: data bits plus parity bit XOR to 0.
                    parity_bad_next = ^{shift_reg, rx_s};
                    state_next      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    complete   = 1'b1;
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Wait here until the line returns high. Otherwise a held-low
                // line would be taken as a new start bit.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    always_comb begin
        take = read_i && valid_reg;
        // A read on the completion edge frees the register in time for the
        // new byte, so that byte is loaded rather than dropped.
        load = complete && (!valid_reg || read_i);
        drop = complete && !load;

        data_next      = load ? shift_reg : data_reg;
        frame_err_next = load ? !rx_s : frame_err_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = load ? parity_bad_reg : parity_err_reg;
`endif

        if (load) begin
            valid_next = 1'b1;
        end else if (take) begin
            valid_next = 1'b0;
        end else begin
            valid_next = valid_reg;
        end

        if (drop) begin
            overrun_next = 1'b1;
        end else if (take) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg;
        end

        // Decode the next state so that busy_o drops on the completion edge.
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_reg      <= 2'b11;
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= 3'd0;
            shift_reg     <= 8'h00;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            sync_reg      <= {sync_reg[0], serial_in_i};
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
            busy_reg      <= busy_next;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= parity_bad_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    assign data_o       = data_reg;
    assign data_valid_o = valid_reg;
    assign frame_err_o  = frame_err_reg;
    assign overrun_o    = overrun_reg;
    assign busy_o       = busy_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (default 8N1 build).
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// the same point.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .serial_in_i  (serial_in),
        .read_i       (read),
        .data_o       (data),
        .data_valid_o (data_valid),
        .frame_err_o  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) tick();
    endtask

    // Send start, 8 data bits LSB first, and the stop bit. The task returns
    // just after edge E0+39, where E0 is the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
        drive_bit(stop);
    endtask

    task automatic read_pulse();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_data", data, 8'h00);
        check("rst_valid", {7'd0, data_valid}, 8'h00);
        check("rst_ferr", {7'd0, frame_err}, 8'h00);
        check("rst_ovr", {7'd0, overrun}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        repeat (3) tick();

        // Frame 0x55 and its latency
        send_frame(8'h55, 1'b1);
        check("55_valid_e39", {7'd0, data_valid}, 8'h00);
        check("55_busy_e39", {7'd0, busy}, 8'h01);
        tick();
        check("55_valid_e40", {7'd0, data_valid}, 8'h01);
        check("55_data", data, 8'h55);
        check("55_ferr", {7'd0, frame_err}, 8'h00);
        check("55_busy_e40", {7'd0, busy}, 8'h00);
        read_pulse();
        check("55_read_clr", {7'd0, data_valid}, 8'h00);

        // Two-clock glitch on the idle line
        repeat (4) tick();
        serial_in = 1'b0;
        tick();
        tick();
        serial_in = 1'b1;
        tick();
        check("glitch_busy_hi", {7'd0, busy}, 8'h01);
        tick();
        tick();
        check("glitch_busy_lo", {7'd0, busy}, 8'h00);
        repeat (50) tick();
        check("glitch_valid", {7'd0, data_valid}, 8'h00);
        check("glitch_ferr", {7'd0, frame_err}, 8'h00);
        check("glitch_ovr", {7'd0, overrun}, 8'h00);

        // Frame 0xA3 with the stop bit low; the line stays low for 12 clocks
        send_frame(8'hA3, 1'b0);
        tick();
        check("a3_data", data, 8'hA3);
        check("a3_valid", {7'd0, data_valid}, 8'h01);
        check("a3_ferr", {7'd0, frame_err}, 8'h01);
        check("a3_busy_break", {7'd0, busy}, 8'h01);
        repeat (7) tick();
        check("a3_hold_busy", {7'd0, busy}, 8'h01);
        check("a3_hold_ovr", {7'd0, overrun}, 8'h00);
        serial_in = 1'b1;
        repeat (4) tick();
        check("a3_idle_busy", {7'd0, busy}, 8'h00);
        repeat (44) tick();
        check("a3_no_spur_ovr", {7'd0, overrun}, 8'h00);
        check("a3_no_spur_data", data, 8'hA3);
        read_pulse();
        repeat (2) tick();

        // Frame 0x0F after the break
        send_frame(8'h0F, 1'b1);
        tick();
        check("0f_data", data, 8'h0F);
        check("0f_valid", {7'd0, data_valid}, 8'h01);
        check("0f_ferr", {7'd0, frame_err}, 8'h00);
        read_pulse();
        repeat (2) tick();

        // Back-to-back frames with no read: overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick();
        check("ovr_data", data, 8'h11);
        check("ovr_flag", {7'd0, overrun}, 8'h01);
        check("ovr_valid", {7'd0, data_valid}, 8'h01);
        read_pulse();
        check("ovr_rd_valid", {7'd0, data_valid}, 8'h00);
        check("ovr_rd_flag", {7'd0, overrun}, 8'h00);
        repeat (2) tick();

        // Read on the exact edge where the second frame completes
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        read = 1'b1;
        tick();
        read = 1'b0;
        check("rdc_valid", {7'd0, data_valid}, 8'h01);
        check("rdc_data", data, 8'h22);
        check("rdc_ovr", {7'd0, overrun}, 8'h00);

        // Reset in the middle of DATA of frame 0xFF (0x22 is still held)
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("mid_busy", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        tick();
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", {7'd0, data_valid}, 8'h00);
        check("mid_rst_ferr", {7'd0, frame_err}, 8'h00);
        check("mid_rst_ovr", {7'd0, overrun}, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        serial_in = 1'b1;
        repeat (8) tick();
        send_frame(8'h3C, 1'b1);
        tick();
        check("3c_data", data, 8'h3C);
        check("3c_valid", {7'd0, data_valid}, 8'h01);
        check("3c_ferr", {7'd0, frame_err}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
